silu_lut_stream: RTL and testbench
==================================

Name: silu_lut_stream

Overview:
Streaming, multi-channel SiLU approximation by table lookup, for the activation stage of quantised layers. Provides DATA_IN_0_PARALLELISM independent lanes that share one runtime-programmable table, with a valid/ready handshake. The output is registered and backed by a skid buffer, so full throughput is sustained under back-pressure. After reset the table holds the default rectifier mapping, so the block works without any programming.

Parameters:
DATA_IN_0_PRECISION_0, 4, lane width W in bits (two's complement); legal range 2..8; output width equals W.
DATA_IN_0_PARALLELISM, 4, number of lanes P; legal range 1..16.
LUT_DEPTH, 2**DATA_IN_0_PRECISION_0, table entries (localparam, not overridable).

Ports:
clk  in  1  single clock; all state updates on the rising edge.
rst  in  1  asynchronous, active-low reset; release is synchronised externally.
data_in_0  in  P*W  input lanes; lane i occupies bits [i*W +: W].
data_in_0_valid  in  1  input beat valid.
data_in_0_ready  out  1  input beat accepted when this and data_in_0_valid are both high.
data_out_0  out  P*W  looked-up lanes, same packing as data_in_0.
data_out_0_valid  out  1  output beat valid.
data_out_0_ready  in  1  downstream accepts the beat.
lut_wr_valid  in  1  table write request.
lut_wr_ready  out  1  write accepted when this and lut_wr_valid are both high.
lut_wr_addr  in  W  table index; the input code, read as unsigned.
lut_wr_data  in  W  new entry value.

Behaviour:
- Reset (rst low, asynchronous):
  - data_out_0_valid = 0, data_out_0 = 0, skid buffer empty.
  - data_in_0_ready = 1 on the first cycle after release; lut_wr_ready = 1.
  - Table reset contents: entry a = a when a[W-1] = 0, entry a = 0 when a[W-1] = 1.
  - The table is reset by the asynchronous reset itself, not by a load sequence.
- Lookup:
  - Combinational on data_in_0, per lane: out_i = table[in_i].
  - The result is captured into the output register when the beat is accepted.
  - Latency: a beat accepted at edge k has data_out_0_valid high after edge k.
- Pipeline states, tracked as occupancy {out_valid, skid_valid}:
  - EMPTY {0,0}: an accepted beat goes to OUT.
  - ONE {1,0}, on an accept:
    - If data_out_0_ready = 1, the new beat replaces OUT and the state stays ONE.
    - Otherwise the new beat goes to SKID and the state becomes FULL {1,1}.
  - ONE, with no accept and data_out_0_ready = 1: the state becomes EMPTY.
  - FULL, with data_out_0_ready = 1: SKID moves to OUT and the state becomes ONE.
  - Beats are never dropped or duplicated; order is preserved.
- data_in_0_ready = !skid_valid && !(lut_wr_valid && lut_wr_ready); it is a function of registered state plus the write request.
- Table write coherence:
  - lut_wr_ready = !out_valid && !skid_valid, i.e. writes are accepted only with the pipeline empty.
  - In a write-accept cycle, data_in_0_ready is forced to 0, so no beat is accepted that cycle.
  - The write takes effect at that edge; the next accepted beat uses the new value.
- Simultaneous events:
  - A pending write and a pending input beat with the pipeline empty: the write wins, and the beat is accepted on the following cycle.
  - A write while the pipeline is occupied stalls (lut_wr_ready = 0) until it drains. Write starvation under continuous input is the system's responsibility.
- Reset mid-operation: in-flight beats are discarded and the table reverts to its default contents.
- data_out_0 holds its value while valid and not ready. Its value when valid = 0 is don't-care, but it must not be X after reset.

Decomposition:
- Package silu_lut_pkg:
  - Function default_entry(addr, W) implementing the reset mapping.
  - Occupancy state typedef (EMPTY/ONE/FULL).
  - Max-width constants.
- One sub-module, lut_skid_stage: a generic width-parameterised output register plus skid buffer. It exports occupancy status for lut_wr_ready.
- The table array and the per-lane lookup generate loop live in the top module.

Test Plan:
1. Post-reset default table: W=4, P=4, lanes {0x3,0x7,0x8,0xF}, out_ready=1 -> {0x3,0x7,0x0,0x0} one cycle later.
2. Throughput: 64 random beats, out_ready=1 -> one output per cycle, in order, data_in_0_ready never low.
3. Back-pressure: hold out_ready=0 for 5 cycles with continuous input -> exactly 2 beats captured and data_in_0_ready low after the second. On release, outputs appear in order with no loss.
4. Table write: with the pipeline empty, write addr 0x9 data 0x5 -> the next beat with lane value 0x9 yields 0x5 and other entries are unchanged. A write and an input beat in the same cycle -> the write accepted first, the beat on the next cycle using the new entry.
5. Write stall: request a write while FULL -> lut_wr_ready=0 until drained, then accepted; beats in flight use the old entry.
6. Async reset mid-stream (FULL, table modified) -> outputs invalid immediately, and the table returns to default (0x9 -> 0x0).

Source files
------------

// File: rtl/silu_lut_pkg.sv
// rtl/silu_lut_pkg.sv - Shared types, limits and default table mapping for silu_lut_stream.
package silu_lut_pkg;

   localparam int MAX_W = 8;
   localparam int MAX_P = 16;

   // Encoding doubles as occupancy: bit 1 = output register valid, bit 0 = skid valid.
   typedef enum logic [1:0] {
      OCC_EMPTY = 2'b00,
      OCC_ONE   = 2'b10,
      OCC_FULL  = 2'b11
   } occ_e;

   // Rectifier mapping: non-negative codes pass through, negative codes map to zero.
   function automatic logic [MAX_W-1:0] default_entry(input int unsigned addr, input int unsigned w);
      logic [MAX_W-1:0] v;
      v = addr[MAX_W-1:0];
      return (((addr >> (w - 1)) & 32'd1) != 32'd0) ? '0 : v;
   endfunction

endpackage

// File: rtl/lut_skid_stage.sv
// rtl/lut_skid_stage.sv - Output register plus skid buffer for a valid/ready stream.
// Occupancy is the state register itself, so status outputs are registered.
module lut_skid_stage
   import silu_lut_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_valid,
   output logic             o_ready,
   output logic [WIDTH-1:0] o_data,
   output logic             o_valid,
   input  logic             i_ready,
   output logic             o_empty
);

   occ_e             r_state;
   logic [WIDTH-1:0] r_out_data;
   logic [WIDTH-1:0] r_skid_data;
   logic             w_accept;

   assign o_ready  = ~r_state[0];
   assign o_valid  = r_state[1];
   assign o_data   = r_out_data;
   assign o_empty  = (r_state == OCC_EMPTY);
   assign w_accept = i_valid & ~r_state[0];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= OCC_EMPTY;
         r_out_data  <= '0;
         r_skid_data <= '0;
      end else begin
         case (r_state)
            OCC_EMPTY: begin
               if (w_accept) begin
                  r_out_data <= i_data;
                  r_state    <= OCC_ONE;
               end
            end
            OCC_ONE: begin
               if (w_accept && i_ready) begin
                  r_out_data <= i_data;
               end else if (w_accept) begin
                  r_skid_data <= i_data;
                  r_state     <= OCC_FULL;
               end else if (i_ready) begin
                  r_state <= OCC_EMPTY;
               end
            end
            OCC_FULL: begin
               if (i_ready) begin
                  r_out_data <= r_skid_data;
                  r_state    <= OCC_ONE;
               end
            end
            default: r_state <= OCC_EMPTY;
         endcase
      end
   end

endmodule

// File: rtl/silu_lut_stream.sv
// rtl/silu_lut_stream.sv - Multi-lane SiLU approximation through a shared programmable table.
// Table writes are only accepted with the pipeline empty so in-flight beats never see a mixed table.
module silu_lut_stream
   import silu_lut_pkg::*;
#(
   parameter int DATA_IN_0_PRECISION_0 = 4,
   parameter int DATA_IN_0_PARALLELISM = 4
) (
   input  logic                                             clk,
   input  logic                                             rst,
   input  logic [DATA_IN_0_PARALLELISM*DATA_IN_0_PRECISION_0-1:0] data_in_0,
   input  logic                                             data_in_0_valid,
   output logic                                             data_in_0_ready,
   output logic [DATA_IN_0_PARALLELISM*DATA_IN_0_PRECISION_0-1:0] data_out_0,
   output logic                                             data_out_0_valid,
   input  logic                                             data_out_0_ready,
   input  logic                                             lut_wr_valid,
   output logic                                             lut_wr_ready,
   input  logic [DATA_IN_0_PRECISION_0-1:0]                 lut_wr_addr,
   input  logic [DATA_IN_0_PRECISION_0-1:0]                 lut_wr_data
);

   localparam int W         = DATA_IN_0_PRECISION_0;
   localparam int P         = DATA_IN_0_PARALLELISM;
   localparam int LUT_DEPTH = 2**DATA_IN_0_PRECISION_0;

   logic [W-1:0]   r_lut [LUT_DEPTH];
   logic [P*W-1:0] w_lookup;
   logic           w_wr_fire;
   logic           w_stage_ready;
   logic           w_stage_empty;
   logic           w_in_valid;

   assign lut_wr_ready    = w_stage_empty;
   assign w_wr_fire       = lut_wr_valid & w_stage_empty;
   assign data_in_0_ready = w_stage_ready & ~w_wr_fire;
   assign w_in_valid      = data_in_0_valid & ~w_wr_fire;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int a = 0; a < LUT_DEPTH; a++) begin
            r_lut[a] <= W'(default_entry(a, W));
         end
      end else if (w_wr_fire) begin
         r_lut[lut_wr_addr] <= lut_wr_data;
      end
   end

   for (genvar i = 0; i < P; i++) begin : g_lane
      assign w_lookup[i*W +: W] = r_lut[data_in_0[i*W +: W]];
   end

   lut_skid_stage #(
      .WIDTH (P*W)
   ) u_stage (
      .i_clk   (clk),
      .i_rst_n (rst),
      .i_data  (w_lookup),
      .i_valid (w_in_valid),
      .o_ready (w_stage_ready),
      .o_data  (data_out_0),
      .o_valid (data_out_0_valid),
      .i_ready (data_out_0_ready),
      .o_empty (w_stage_empty)
   );

endmodule

// File: tb/tb_silu_lut_stream.sv
// tb/tb_silu_lut_stream.sv - Scoreboard bench for silu_lut_stream (W=4, P=4).
module tb_silu_lut_stream;

   logic        clk;
   logic        rst_n;
   logic [15:0] data_in_0;
   logic        data_in_0_valid;
   logic        data_in_0_ready;
   logic [15:0] data_out_0;
   logic        data_out_0_valid;
   logic        data_out_0_ready;
   logic        lut_wr_valid;
   logic        lut_wr_ready;
   logic [3:0]  lut_wr_addr;
   logic [3:0]  lut_wr_data;

   int          checks;
   int          failures;
   int          out_cnt;
   int          stall_cnt;
   logic        in_acc;
   logic        wr_acc;
   logic [3:0]  model_lut [16];
   logic [15:0] exp_q [$];

   silu_lut_stream #(
      .DATA_IN_0_PRECISION_0 (4),
      .DATA_IN_0_PARALLELISM (4)
   ) dut (
      .clk              (clk),
      .rst              (rst_n),
      .data_in_0        (data_in_0),
      .data_in_0_valid  (data_in_0_valid),
      .data_in_0_ready  (data_in_0_ready),
      .data_out_0       (data_out_0),
      .data_out_0_valid (data_out_0_valid),
      .data_out_0_ready (data_out_0_ready),
      .lut_wr_valid     (lut_wr_valid),
      .lut_wr_ready     (lut_wr_ready),
      .lut_wr_addr      (lut_wr_addr),
      .lut_wr_data      (lut_wr_data)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1);
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int a = 0; a < 16; a++) model_lut[a] = (a >= 8) ? 4'h0 : 4'(a);
   endtask

   function automatic logic [15:0] model_out(input logic [15:0] d);
      logic [15:0] r;
      for (int l = 0; l < 4; l++) r[l*4 +: 4] = model_lut[d[l*4 +: 4]];
      return r;
   endfunction

   // Scoreboard: pop on output handshake, push on input handshake, track table writes.
   always @(negedge clk) begin
      if (rst_n) begin
         if (data_out_0_valid && data_out_0_ready) begin
            out_cnt++;
            check_eq("sb_has_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) check_eq("sb_data", data_out_0, exp_q.pop_front());
         end
         if (data_in_0_valid && !data_in_0_ready) stall_cnt++;
         if (data_in_0_valid && data_in_0_ready) exp_q.push_back(model_out(data_in_0));
         if (lut_wr_valid && lut_wr_ready) model_lut[lut_wr_addr] = lut_wr_data;
      end
   end

   // Called at posedge+1; samples handshakes mid-cycle, returns at the next posedge+1.
   task automatic cycle();
      @(negedge clk);
      #1;
      in_acc = data_in_0_valid && data_in_0_ready;
      wr_acc = lut_wr_valid && lut_wr_ready;
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || data_out_0_valid) && n < 20) begin
         cycle();
         n++;
      end
      check_eq("drain_empty", exp_q.size(), 0);
   endtask

   initial begin
      int idx;
      int n;
      int bad;
      int base;
      logic [15:0] beats [5];

      checks = 0; failures = 0; out_cnt = 0; stall_cnt = 0;
      in_acc = 0; wr_acc = 0;
      rst_n = 1'b0;
      data_in_0 = '0; data_in_0_valid = 0; data_out_0_ready = 0;
      lut_wr_valid = 0; lut_wr_addr = '0; lut_wr_data = '0;
      model_reset();

      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_out_valid", data_out_0_valid, 0);
      check_eq("rst_out_data", data_out_0, 0);
      rst_n = 1'b1;
      #1;
      check_eq("rst_in_ready", data_in_0_ready, 1);
      check_eq("rst_wr_ready", lut_wr_ready, 1);
      @(posedge clk);
      #1;

      // Default table lookup and one-cycle latency
      data_out_0_ready = 1;
      data_in_0 = 16'hF873; data_in_0_valid = 1;
      cycle();
      check_eq("t1_accept", in_acc, 1);
      data_in_0_valid = 0;
      check_eq("t1_valid", data_out_0_valid, 1);
      check_eq("t1_data", data_out_0, 16'h0073);
      drain();

      // Full throughput with random beats
      stall_cnt = 0;
      base = out_cnt;
      for (int i = 0; i < 64; i++) begin
         data_in_0 = 16'($urandom); data_in_0_valid = 1;
         cycle();
      end
      data_in_0_valid = 0;
      drain();
      check_eq("t2_no_stall", stall_cnt, 0);
      check_eq("t2_out_count", out_cnt - base, 64);

      // Back-pressure: two beats fit, then input stalls
      for (int i = 0; i < 5; i++) beats[i] = 16'($urandom);
      data_out_0_ready = 0;
      idx = 0;
      for (int c = 0; c < 5; c++) begin
         data_in_0 = beats[idx]; data_in_0_valid = 1;
         cycle();
         if (in_acc) idx++;
      end
      check_eq("t3_captured", idx, 2);
      check_eq("t3_in_ready_low", data_in_0_ready, 0);
      data_in_0_valid = 0;
      data_out_0_ready = 1;
      drain();

      // Table write with empty pipeline
      lut_wr_valid = 1; lut_wr_addr = 4'h9; lut_wr_data = 4'h5;
      cycle();
      check_eq("t4_wr_accept", wr_acc, 1);
      lut_wr_valid = 0;
      data_in_0 = 16'hA299; data_in_0_valid = 1;
      cycle();
      data_in_0_valid = 0;
      check_eq("t4_new_entry", data_out_0, 16'h0255);
      drain();

      // Write and beat in the same cycle: write first
      lut_wr_valid = 1; lut_wr_addr = 4'hA; lut_wr_data = 4'h6;
      data_in_0 = 16'h00AA; data_in_0_valid = 1;
      cycle();
      check_eq("t4_same_wr", wr_acc, 1);
      check_eq("t4_same_in_blocked", in_acc, 0);
      lut_wr_valid = 0;
      cycle();
      check_eq("t4_beat_next", in_acc, 1);
      data_in_0_valid = 0;
      check_eq("t4_beat_data", data_out_0, 16'h0066);
      drain();

      // Write stalls while pipeline occupied
      data_out_0_ready = 0;
      data_in_0 = 16'h9999; data_in_0_valid = 1;
      cycle();
      cycle();
      data_in_0_valid = 0;
      check_eq("t5_full", exp_q.size(), 2);
      lut_wr_valid = 1; lut_wr_addr = 4'h9; lut_wr_data = 4'hC;
      bad = 0;
      for (int c = 0; c < 3; c++) begin
         cycle();
         if (wr_acc) bad++;
      end
      check_eq("t5_wr_stalled", bad, 0);
      data_out_0_ready = 1;
      n = 0;
      wr_acc = 0;
      while (!wr_acc && n < 20) begin
         cycle();
         n++;
      end
      lut_wr_valid = 0;
      check_eq("t5_wr_accept", wr_acc, 1);
      check_eq("t5_wr_wait", n, 3);
      data_in_0 = 16'h9999; data_in_0_valid = 1;
      cycle();
      data_in_0_valid = 0;
      check_eq("t5_new_entry", data_out_0, 16'hCCCC);
      drain();

      // Async reset while full with modified table
      data_out_0_ready = 0;
      data_in_0 = 16'h1234; data_in_0_valid = 1;
      cycle();
      cycle();
      data_in_0_valid = 0;
      check_eq("t6_full", data_out_0_valid && !data_in_0_ready, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("t6_rst_valid", data_out_0_valid, 0);
      check_eq("t6_rst_data", data_out_0, 0);
      exp_q.delete();
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      data_out_0_ready = 1;
      check_eq("t6_wr_ready", lut_wr_ready, 1);
      data_in_0 = 16'hA979; data_in_0_valid = 1;
      cycle();
      data_in_0_valid = 0;
      check_eq("t6_accept", in_acc, 1);
      check_eq("t6_default_table", data_out_0, 16'h0070);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
